// File: rtl/poly_byte_encode_pkg.sv
// Shared ML-KEM types and constants for the polynomial byte encoder.
package TYPES_KEM;

    localparam int ML_KEM_N = 256;
    localparam int ML_KEM_Q = 3329;

    typedef logic [11:0] coef_t;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } enc_state_t;

endpackage

// File: rtl/poly_byte_encode_cond_sub_q.sv
// Single conditional subtraction of q, folding [q, 4096) back into canonical range.
module cond_sub_q
    import TYPES_KEM::*;
(
    input  coef_t coef,
    output coef_t reduced
);

    // Subtract q once when the value is at or above q.
    always_comb begin
        reduced = coef;
        if (coef >= coef_t'(ML_KEM_Q)) begin
            reduced = coef - coef_t'(ML_KEM_Q);
        end
    end

endmodule

// File: rtl/poly_byte_encode.sv
// ByteEncode_D: packs 256 D-bit coefficients LSB-first into 64-bit words.
// Optional macro POLY_BYTE_ENCODE_MODQ_EN reduces each coefficient mod q
// (single conditional subtract) before packing when D is 12.
module poly_byte_encode
    import TYPES_KEM::*;
#(
    parameter int D     = 12,
    parameter int OUT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             run_i,
    input  logic [11:0]      coef_i,
    input  logic             coef_valid_i,
    output logic             coef_ready_o,
    output logic [OUT_W-1:0] data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             busy_o,
    output logic             done_o
);

    localparam int         BUF_W     = OUT_W + D;
    localparam logic [5:0] LAST_WORD = 6'(4 * D - 1);
    localparam logic [6:0] WORD_BITS = 7'(OUT_W);

    enc_state_t       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d, buf_popped;
    logic [6:0]       fill_q, fill_d, fill_popped;
    logic [8:0]       coef_cnt_q, coef_cnt_d;
    logic [5:0]       word_cnt_q, word_cnt_d;
    logic             active, pop, push, start;
    coef_t            packed_coef;
    logic [D-1:0]     coef_bits;

`ifdef POLY_BYTE_ENCODE_MODQ_EN
    generate
        if (D == 12) begin : g_modq
            coef_t reduced;
            cond_sub_q u_cond_sub_q (
                .coef    (coef_i),
                .reduced (reduced)
            );
            assign packed_coef = reduced;
        end else begin : g_raw
            assign packed_coef = coef_i;
        end
    endgenerate
`else
    assign packed_coef = coef_i;
`endif

    assign coef_bits = packed_coef[D-1:0];

    assign active = (state_q == ACTIVE);
    assign start  = (state_q == IDLE) && run_i;
    assign pop    = valid_o && ready_i;
    assign push   = coef_ready_o && coef_valid_i;

    assign valid_o      = active && (fill_q >= WORD_BITS);
    assign coef_ready_o = active && (coef_cnt_q < 9'(ML_KEM_N))
                          && ((fill_q < WORD_BITS) || ready_i);
    assign data_o       = buf_q[OUT_W-1:0];
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DONE);

    // Next FSM state: leave ACTIVE on the handshake of the last word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (run_i) state_d = ACTIVE;
            ACTIVE:  if (pop && (word_cnt_q == LAST_WORD)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Buffer update: pop the low word first, then append the new coefficient.
    always_comb begin
        buf_popped  = pop ? (buf_q >> OUT_W) : buf_q;
        fill_popped = pop ? (fill_q - WORD_BITS) : fill_q;
        buf_d       = buf_popped;
        fill_d      = fill_popped;
        coef_cnt_d  = coef_cnt_q;
        word_cnt_d  = word_cnt_q;
        if (push) begin
            buf_d      = buf_popped | ({{OUT_W{1'b0}}, coef_bits} << fill_popped);
            fill_d     = fill_popped + 7'(D);
            coef_cnt_d = coef_cnt_q + 9'd1;
        end
        if (pop) begin
            word_cnt_d = word_cnt_q + 6'd1;
        end
        if (start) begin
            buf_d      = '0;
            fill_d     = '0;
            coef_cnt_d = '0;
            word_cnt_d = '0;
        end
    end

    // Bit buffer and counter registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            buf_q      <= '0;
            fill_q     <= '0;
            coef_cnt_q <= '0;
            word_cnt_q <= '0;
        end else begin
            buf_q      <= buf_d;
            fill_q     <= fill_d;
            coef_cnt_q <= coef_cnt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

endmodule

// File: doc/poly_byte_encode.md
# poly_byte_encode

Serialises one ML-KEM polynomial (256 coefficients of D bits) into a little-endian packed stream of 64-bit words, implementing ByteEncode_D. It is the encoding counterpart of the XOF-driven sampling path: the samplers turn byte streams into coefficients, and this block turns coefficients back into bytes for public-key and ciphertext output. It sits between the polynomial store or NTT output and the byte-stream/hash interface.

## Interface
- `D`, 12, coefficient bit width packed per coefficient; legal range 1..12.
- `OUT_W`, 64, output word width; fixed at 64.
- `clk_i` in 1: single clock; all logic on its rising edge.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `run_i` in 1: start encoding one polynomial; honoured only in IDLE.
- `coef_i` in 12: coefficient; only the low D bits are packed.
- `coef_valid_i` in 1: `coef_i` is valid.
- `coef_ready_o` out 1: block accepts `coef_i` this cycle.
- `data_o` out 64: packed output word.
- `valid_o` out 1: `data_o` is valid.
- `ready_i` in 1: downstream accepts `data_o`.
- `busy_o` out 1: encoding in progress.
- `done_o` out 1: one-cycle pulse when the polynomial is fully emitted.

## Operation
- FSM states:
  - IDLE: `run_i` moves to ACTIVE and clears the coefficient counter, word counter and buffer.
  - ACTIVE: accepts coefficients and emits words; goes to DONE on the handshake of word number 4·D, the last word.
  - DONE: lasts one cycle, asserts `done_o`, then returns to IDLE.
- Bit buffer `buf_q` is 64+D bits wide, with fill count `fill_q` (7 bits).
  - Coefficients are appended LSB-first at bit position `fill` after any pop.
  - `data_o` is `buf_q[63:0]`.
- Output side:
  - `valid_o` = ACTIVE && `fill_q` ≥ 64.
  - A pop (`valid_o` && `ready_i`) shifts the buffer right by 64 and subtracts 64 from `fill_q`.
- Input side:
  - `coef_ready_o` = ACTIVE && coef_cnt < 256 && (`fill_q` < 64 || `ready_i`).
  - This makes a combinational path from `ready_i` to `coef_ready_o`, which is intentional.
- Simultaneous push and pop in one cycle: the pop is applied first, then the push. New fill = `fill_q` − 64 + D.
- Counters:
  - coef_cnt is 9 bits and saturates at 256.
  - word_cnt is 6 bits and ends at 4·D (48 for D=12).
  - 256·D is always a multiple of 64, so no flush or padding is ever needed.
  - The buffer is empty when the last word pops.
- `run_i` while busy (ACTIVE or DONE) is ignored.
- Coefficients offered while in IDLE or DONE are not accepted (`coef_ready_o`=0).

## Timing
- Reset values: `coef_ready_o`, `valid_o`, `busy_o` and `done_o` are 0; `data_o` is 0; FSM is in IDLE; buffer and counters are 0.
- `run_i` sampled high in IDLE gives `busy_o`=1 from the next cycle.
- The first word becomes valid on the cycle after the ceil(64/D)-th coefficient is accepted (the 6th coefficient for D=12).
- Throughput: one coefficient per cycle with `ready_i` held high; 256 accepts for 48 words.
- `done_o` pulses the cycle after the final word handshake.
  - `busy_o` is still 1 in that cycle and drops in the following cycle.
  - Minimum start-to-done latency for D=12 is 258 cycles.
- `data_o` and `valid_o` stay stable while `valid_o` && !`ready_i`.
- Reset mid-operation returns to IDLE with all state cleared, no `done_o`, and no partial word emitted.

## Configuration
- Macro: `POLY_BYTE_ENCODE_MODQ_EN`.
- Defined:
  - Each coefficient passes through a conditional subtract before packing: if c ≥ 3329 then c−3329.
  - This is applied only when D=12; other D values are unaffected.
  - The subtract is combinational in front of the buffer, with no added latency.
- Undefined:
  - The low D bits are packed unmodified.
  - Upstream guarantees the canonical range [0, q).

## Structure
- `TYPES_KEM` package holds:
  - Constants `ML_KEM_N`=256 and `ML_KEM_Q`=3329.
  - `typedef logic [11:0] coef_t`.
  - An FSM state enum `enc_state_t` {IDLE, ACTIVE, DONE}.
- One sub-module, `cond_sub_q`: 12-bit combinational c ≥ q ? c−q : c. It is instantiated only under the macro.

## Test plan
- D=12, coefficients 0,1,2,…,255, `ready_i`=1: word0 = 0x5004003002001000; 48 words total; `done_o` pulses once at cycle 258 after `run_i`.
- D=12, all coefficients 0xFFF:
  - With macro: every coefficient packs as 0x2FE, so word0 = 0xE2FE2FE2FE2FE2FE.
  - Without macro: every word is 0xFFFFFFFFFFFFFFFF.
- `ready_i` low for 10 cycles after the first `valid_o`: `coef_ready_o` drops, and `data_o` stays at 0x5004003002001000 until accepted. No coefficient is lost, and the 48-word stream is unchanged.
- `run_i` pulsed again mid-polynomial: ignored; exactly 48 words and one `done_o` result.
- `rst_n_i` low at word 20 for one cycle: all outputs 0 and FSM in IDLE. A new `run_i` then produces a clean 48-word stream.
- D=1, coefficients alternating 1,0: 4 words, each 0x5555555555555555, then `done_o`.
